// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RISC core: branch-select codes, PC mux codes
// and the branch sequencer state type.
package riscv_ctrl_pkg;

    localparam logic [1:0] BS_NONE = 2'b00;
    localparam logic [1:0] BS_COND = 2'b01;
    localparam logic [1:0] BS_JREG = 2'b10;
    localparam logic [1:0] BS_JIMM = 2'b11;

    localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
    localparam logic [1:0] PC_SEL_BRA   = 2'd1;
    localparam logic [1:0] PC_SEL_RAA   = 2'd2;
    localparam logic [1:0] PC_SEL_BRA_J = 2'd3;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } seq_state_t;

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating event counter: counts up on inc and holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/branch_sequencer.sv
// EX-stage branch sequencer: resolves the branch decision, drives the PC mux and
// redirect target, bubbles IF/DE after a redirect and arbitrates load-use stalls.
module branch_sequencer
    import riscv_ctrl_pkg::*;
#(
    parameter int PC_W        = 8,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             ex_valid,
    input  logic [1:0]       BS,
    input  logic             PS,
    input  logic             Z,
    input  logic [PC_W-1:0]  BrA,
    input  logic [PC_W-1:0]  RAA,
    input  logic             hazard_stall,
    output logic [1:0]       pc_sel,
    output logic [PC_W-1:0]  target_pc,
    output logic             pc_en,
    output logic             flush_if,
    output logic             flush_de,
    output logic             stall,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

    seq_state_t state;
    logic [2:0] flush_cnt;
    logic       accept;
    logic       cond_met;
    logic       taken;
    logic       branch_seen;

    // Reset gates the decision so outputs return to idle values without waiting for an edge.
    assign accept      = ex_valid & (state == RUN) & ~reset;
    assign cond_met    = (BS == BS_COND) & (PS ^ Z);
    assign taken       = accept & (BS[1] | cond_met);
    assign branch_seen = accept & (BS != BS_NONE);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        pc_sel    = PC_SEL_SEQ;
        target_pc = '0;
        pc_en     = 1'b1;
        flush_if  = 1'b0;
        flush_de  = 1'b0;
        stall     = 1'b0;
        busy      = 1'b0;
        if (!reset) begin
            if (state == FLUSH) begin
                flush_if = 1'b1;
                flush_de = 1'b1;
                busy     = 1'b1;
            end else if (taken) begin
                // Redirect beats a load-use stall: the EX instruction is older than DE.
                unique case (BS)
                    BS_JREG: begin
                        pc_sel    = PC_SEL_RAA;
                        target_pc = RAA;
                    end
                    BS_JIMM: begin
                        pc_sel    = PC_SEL_BRA_J;
                        target_pc = BrA;
                    end
                    default: begin
                        pc_sel    = PC_SEL_BRA;
                        target_pc = BrA;
                    end
                endcase
                flush_if = 1'b1;
                flush_de = 1'b1;
            end else if (hazard_stall) begin
                pc_en = 1'b0;
                stall = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (taken && (FLUSH_DEPTH > 1)) begin
                        flush_cnt <= FLUSH_LOAD;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    flush_cnt <= flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
        .CLK   (CLK),
        .reset (reset),
        .inc   (branch_seen),
        .count (branch_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
        .CLK   (CLK),
        .reset (reset),
        .inc   (taken),
        .count (taken_cnt)
    );

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the branch/flush/stall rules.
module tb_branch_sequencer;

    localparam int PC_W        = 8;
    localparam int FLUSH_DEPTH = 2;
    localparam int CNT_W       = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;
    localparam int OBS_W       = 2 + PC_W + 5 + 2 * CNT_W;

    logic             CLK = 1'b0;
    logic             reset;
    logic             ex_valid;
    logic [1:0]       BS;
    logic             PS;
    logic             Z;
    logic [PC_W-1:0]  BrA;
    logic [PC_W-1:0]  RAA;
    logic             hazard_stall;
    logic [1:0]       pc_sel;
    logic [PC_W-1:0]  target_pc;
    logic             pc_en;
    logic             flush_if;
    logic             flush_de;
    logic             stall;
    logic             busy;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] taken_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state: bubble cycles still owed, and event totals.
    int flush_left = 0;
    int n_branch   = 0;
    int n_taken    = 0;

    branch_sequencer #(
        .PC_W        (PC_W),
        .FLUSH_DEPTH (FLUSH_DEPTH),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .BS           (BS),
        .PS           (PS),
        .Z            (Z),
        .BrA          (BrA),
        .RAA          (RAA),
        .hazard_stall (hazard_stall),
        .pc_sel       (pc_sel),
        .target_pc    (target_pc),
        .pc_en        (pc_en),
        .flush_if     (flush_if),
        .flush_de     (flush_de),
        .stall        (stall),
        .busy         (busy),
        .branch_cnt   (branch_cnt),
        .taken_cnt    (taken_cnt)
    );

    always #5 CLK = ~CLK;

    function automatic logic [OBS_W-1:0] observed();
        return {pc_sel, target_pc, pc_en, flush_if, flush_de, stall, busy, branch_cnt, taken_cnt};
    endfunction

    function automatic bit model_taken();
        bit cond;
        cond = (BS == 2'b01) && (PS ? (Z == 1'b0) : (Z == 1'b1));
        return !reset && (flush_left == 0) && ex_valid && (BS == 2'b10 || BS == 2'b11 || cond);
    endfunction

    function automatic logic [OBS_W-1:0] expected();
        logic [1:0]      sel;
        logic [PC_W-1:0] tgt;
        logic            en, fi, fd, st, bz;
        logic [CNT_W-1:0] cb, ct;
        sel = 2'd0; tgt = '0; en = 1'b1; fi = 1'b0; fd = 1'b0; st = 1'b0; bz = 1'b0;
        cb = reset ? '0 : CNT_W'(n_branch);
        ct = reset ? '0 : CNT_W'(n_taken);
        if (!reset) begin
            if (flush_left > 0) begin
                fi = 1'b1; fd = 1'b1; bz = 1'b1;
            end else if (model_taken()) begin
                sel = (BS == 2'b01) ? 2'd1 : (BS == 2'b10) ? 2'd2 : 2'd3;
                tgt = (BS == 2'b10) ? RAA : BrA;
                fi  = 1'b1; fd = 1'b1;
            end else if (hazard_stall) begin
                en = 1'b0; st = 1'b1;
            end
        end
        return {sel, tgt, en, fi, fd, st, bz, cb, ct};
    endfunction

    // Advance the model across one rising edge using the inputs currently applied.
    task automatic model_clock();
        bit tk;
        tk = model_taken();
        if (reset) begin
            flush_left = 0; n_branch = 0; n_taken = 0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else begin
            if (ex_valid && BS != 2'b00 && n_branch < CNT_MAX) n_branch++;
            if (tk) begin
                if (n_taken < CNT_MAX) n_taken++;
                flush_left = FLUSH_DEPTH - 1;
            end
        end
    endtask

    task automatic apply(input logic v, input logic [1:0] bs, input logic ps, input logic z,
                         input logic [PC_W-1:0] bra, input logic [PC_W-1:0] raa, input logic hz);
        ex_valid = v; BS = bs; PS = ps; Z = z; BrA = bra; RAA = raa; hazard_stall = hz;
        #1;
    endtask

    task automatic tick();
        model_clock();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic idle();
        apply(1'b0, 2'b00, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_clock();
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [OBS_W-1:0] obs;
        logic [OBS_W-1:0] exp;
        pulse_reset();
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
        tick();
        idle();
        tick();
        apply(1'b1, 2'b01, 1'b1, 1'b0, 8'h33, 8'h00, 1'b1);
        reset = 1'b1;
        #1;
        checks++;
        if (pc_sel !== 2'd0 || target_pc !== '0 || pc_en !== 1'b1 || flush_if !== 1'b0 ||
            flush_de !== 1'b0 || stall !== 1'b0 || busy !== 1'b0 ||
            branch_cnt !== '0 || taken_cnt !== '0) begin
            errors++;
            $display("FAIL reset_values: got %h", observed());
        end
        model_clock();
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        idle();
        obs = observed();
        exp = expected();
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL reset_release: got %h expected %h", obs, exp);
        end
    endtask

    task automatic test_cond_branch();
        pulse_reset();
        apply(1'b1, 2'b01, 1'b0, 1'b0, 8'h40, 8'h00, 1'b0);
        checks++;
        if (pc_sel !== 2'd0 || flush_if !== 1'b0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL cond_not_taken: pc_sel=%0d flush_if=%b pc_en=%b required 0 0 1",
                     pc_sel, flush_if, pc_en);
        end
        tick();
        idle();
        checks++;
        if (branch_cnt !== 4'd1 || taken_cnt !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cond_not_taken_cnt: branch=%0d taken=%0d busy=%b required 1 0 0",
                     branch_cnt, taken_cnt, busy);
        end
        apply(1'b1, 2'b01, 1'b0, 1'b1, 8'h40, 8'h00, 1'b0);
        checks++;
        if (pc_sel !== 2'd1 || target_pc !== 8'h40 || flush_if !== 1'b1 || flush_de !== 1'b1) begin
            errors++;
            $display("FAIL cond_taken: pc_sel=%0d target=%h flush=%b%b required 1 40 11",
                     pc_sel, target_pc, flush_if, flush_de);
        end
        tick();
        idle();
        checks++;
        if (flush_if !== 1'b1 || flush_de !== 1'b1 || busy !== 1'b1 || pc_sel !== 2'd0) begin
            errors++;
            $display("FAIL cond_flush2: flush=%b%b busy=%b pc_sel=%0d required 11 1 0",
                     flush_if, flush_de, busy, pc_sel);
        end
        tick();
        idle();
        checks++;
        if (flush_if !== 1'b0 || busy !== 1'b0 || taken_cnt !== 4'd1 || branch_cnt !== 4'd2) begin
            errors++;
            $display("FAIL cond_after_flush: flush_if=%b busy=%b taken=%0d branch=%0d required 0 0 1 2",
                     flush_if, busy, taken_cnt, branch_cnt);
        end
    endtask

    task automatic test_jump_reg();
        apply(1'b1, 2'b10, 1'b0, 1'b0, 8'h55, 8'h9C, 1'b0);
        checks++;
        if (pc_sel !== 2'd2 || target_pc !== 8'h9C) begin
            errors++;
            $display("FAIL jreg: pc_sel=%0d target=%h required 2 9c", pc_sel, target_pc);
        end
        tick();
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h22, 8'h00, 1'b1);
        checks++;
        if (busy !== 1'b1 || pc_sel !== 2'd0 || target_pc !== '0 || stall !== 1'b0 || pc_en !== 1'b1) begin
            errors++;
            $display("FAIL jreg_ignore: busy=%b pc_sel=%0d target=%h stall=%b pc_en=%b required 1 0 00 0 1",
                     busy, pc_sel, target_pc, stall, pc_en);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_hazard();
        for (int i = 0; i < 3; i++) begin
            apply(i[0], 2'b00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
            checks++;
            if (pc_en !== 1'b0 || stall !== 1'b1 || flush_if !== 1'b0 || pc_sel !== 2'd0) begin
                errors++;
                $display("FAIL hazard_%0d: pc_en=%b stall=%b flush_if=%b pc_sel=%0d required 0 1 0 0",
                         i, pc_en, stall, flush_if, pc_sel);
            end
            tick();
        end
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h10, 8'hEE, 1'b1);
        checks++;
        if (pc_sel !== 2'd3 || target_pc !== 8'h10 || stall !== 1'b0 || pc_en !== 1'b1 ||
            flush_if !== 1'b1 || flush_de !== 1'b1) begin
            errors++;
            $display("FAIL hazard_vs_jimm: got %h", observed());
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_reset_in_flush();
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h61, 8'h00, 1'b0);
        tick();
        idle();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL flush_entry: busy=%b required 1", busy);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || flush_if !== 1'b0 || flush_de !== 1'b0 || pc_en !== 1'b1 ||
            branch_cnt !== '0 || taken_cnt !== '0) begin
            errors++;
            $display("FAIL reset_in_flush: got %h", observed());
        end
        model_clock();
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        apply(1'b1, 2'b11, 1'b0, 1'b0, 8'h77, 8'h00, 1'b0);
        checks++;
        if (pc_sel !== 2'd3 || target_pc !== 8'h77 || flush_if !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_branch: pc_sel=%0d target=%h flush_if=%b required 3 77 1",
                     pc_sel, target_pc, flush_if);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_saturation();
        pulse_reset();
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 2'b11, 1'b0, 1'b0, 8'(i), 8'h00, 1'b0);
            tick();
            idle();
            tick();
        end
        checks++;
        if (taken_cnt !== 4'hF || branch_cnt !== 4'hF) begin
            errors++;
            $display("FAIL saturate: taken=%h branch=%h required f f", taken_cnt, branch_cnt);
        end
    endtask

    task automatic test_random();
        logic [OBS_W-1:0] obs;
        logic [OBS_W-1:0] exp;
        pulse_reset();
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            apply(1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
            obs = observed();
            exp = expected();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, obs, exp);
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        ex_valid = 1'b0; BS = 2'b00; PS = 1'b0; Z = 1'b0;
        BrA = '0; RAA = '0; hazard_stall = 1'b0;
        @(negedge CLK);
        test_reset();
        test_cond_branch();
        test_jump_reg();
        test_hazard();
        test_reset_in_flush();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
